// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard over open-drain clock/data.
// Optional define PS2_TX_GLITCH_FILTER_EN adds an 8-sample agreement filter on the synced PS/2 clock.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       wr,
  input  logic       addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       wt,
  output logic       irq,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - INHIBIT_CYCLES / 2);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAITIDLE
  } state_t;

  state_t        state, state_n;
  logic [7:0]    tx_byte, tx_byte_n;
  logic          ready, ready_n;
  logic          ien, ien_n;
  logic          err, err_n;
  logic          data_oe_r, data_oe_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;

  logic clk_s1, clk_s2, data_s1, data_s2;
  logic clk_lvl, clk_prev, fall;
  logic wr_data, wr_ctrl, parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [7:0] filt_sh;
  logic       clk_filt;

  // The filtered level only moves once the last 8 samples all agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_sh  <= 8'hFF;
      clk_filt <= 1'b1;
    end else begin
      filt_sh <= {filt_sh[6:0], clk_s2};
      if (&filt_sh)
        clk_filt <= 1'b1;
      else if (~|filt_sh)
        clk_filt <= 1'b0;
    end
  end

  assign clk_lvl = clk_filt;
`else
  assign clk_lvl = clk_s2;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      clk_prev <= 1'b1;
    else
      clk_prev <= clk_lvl;
  end

  assign fall    = clk_prev & ~clk_lvl;
  assign wr_data = en & wr & ~addr;
  assign wr_ctrl = en & wr & addr;
  assign parity  = ~^tx_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tx_byte   <= 8'h00;
      ready     <= 1'b1;
      ien       <= 1'b0;
      err       <= 1'b0;
      data_oe_r <= 1'b0;
      inh_cnt   <= '0;
      bit_cnt   <= 4'd0;
      to_cnt    <= '0;
    end else begin
      state     <= state_n;
      tx_byte   <= tx_byte_n;
      ready     <= ready_n;
      ien       <= ien_n;
      err       <= err_n;
      data_oe_r <= data_oe_n;
      inh_cnt   <= inh_cnt_n;
      bit_cnt   <= bit_cnt_n;
      to_cnt    <= to_cnt_n;
    end
  end

  // Data is shifted out on device-generated falling edges; the timeout check overrides everything else.
  always_comb begin
    state_n   = state;
    tx_byte_n = tx_byte;
    ready_n   = ready;
    ien_n     = ien;
    err_n     = err;
    data_oe_n = data_oe_r;
    inh_cnt_n = inh_cnt;
    bit_cnt_n = bit_cnt;
    to_cnt_n  = to_cnt;

    if (wr_ctrl)
      ien_n = data_in[1];

    case (state)
      S_IDLE: begin
        data_oe_n = 1'b0;
        if (wr_data && ready) begin
          tx_byte_n = data_in;
          ready_n   = 1'b0;
          err_n     = 1'b0;
          inh_cnt_n = '0;
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          bit_cnt_n = 4'd0;
          to_cnt_n  = '0;
          state_n   = S_SEND;
        end else begin
          inh_cnt_n = inh_cnt + IW'(1);
        end
      end
      S_SEND: begin
        to_cnt_n = to_cnt + TW'(1);
        if (fall) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            data_oe_n = ~tx_byte[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            data_oe_n = ~parity;
          end else begin
            data_oe_n = 1'b0;
            state_n   = S_ACK;
          end
        end
      end
      S_ACK: begin
        to_cnt_n = to_cnt + TW'(1);
        if (fall) begin
          if (data_s2)
            err_n = 1'b1;
          state_n = S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        if (clk_lvl && data_s2) begin
          ready_n = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if ((state == S_SEND || state == S_ACK) && to_cnt == TO_LAST) begin
      data_oe_n = 1'b0;
      err_n     = 1'b1;
      ready_n   = 1'b1;
      state_n   = S_IDLE;
    end
  end

  assign ps2_clk_oe  = (state == S_INHIBIT);
  // Start bit occupies the second half of the inhibit window, then the register holds the line.
  assign ps2_data_oe = (state == S_INHIBIT) ? (inh_cnt >= INH_START) : data_oe_r;

  assign data_out = addr ? {5'b00000, err, ien, ready} : tx_byte;
  assign wt       = 1'b0;
  assign irq      = ready & ien;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx with a small PS/2 keyboard model driving the open-drain lines.
// Short inhibit/timeout parameters keep each frame to a few hundred cycles.
module tb_ps2_tx;

  localparam int INH = 20;
  localparam int TMO = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, wr, addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       wt, irq;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       kbd_clk, kbd_data;
  logic       ps2_clk_line, ps2_data_line;

  int n_checks = 0;
  int n_pass   = 0;

  assign ps2_clk_line  = kbd_clk & ~ps2_clk_oe;
  assign ps2_data_line = kbd_data & ~ps2_data_oe;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .wr          (wr),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .wt          (wt),
    .irq         (irq),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic a, input logic [7:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic readReg(input logic a, output logic [7:0] d);
    addr = a; en = 1'b1; wr = 1'b0;
    #1;
    d = data_out;
    en = 1'b0;
  endtask

  task automatic waitRelease(input string tag);
    int n = 0;
    while (!ps2_clk_oe && n < 50) begin n++; @(negedge clk); end
    while (ps2_clk_oe && n < 200) begin n++; @(negedge clk); end
    checkOutput(tag, 16'(n >= 200 || ps2_clk_oe), 16'h0);
  endtask

  task automatic waitReady(input string tag, input int bound);
    int n = 0;
    while (data_out[0] !== 1'b1 && n < bound) begin
      addr = 1'b1; #1;
      if (data_out[0] !== 1'b1) begin n++; @(negedge clk); end
    end
    checkOutput(tag, 16'(n >= bound), 16'h0);
  endtask

  // Keyboard model: drives clock pulses, samples the line at the end of each low phase,
  // and optionally clocks an eleventh ack pulse (pulling data low only when ack is set).
  task automatic kbdClock(input int pulses, input bit ack_slot, input bit ack, output logic [9:0] cap);
    cap = '0;
    repeat (5) @(negedge clk);
    for (int p = 0; p < pulses; p++) begin
      kbd_clk = 1'b0;
      repeat (10) @(negedge clk);
      if (p < 10) cap[p] = ps2_data_line;
      kbd_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    if (ack_slot) begin
      if (ack) kbd_data = 1'b0;
      repeat (4) @(negedge clk);
      kbd_clk = 1'b0;
      repeat (10) @(negedge clk);
      kbd_clk = 1'b1;
      repeat (4) @(negedge clk);
      kbd_data = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [9:0] cap;
    int inh_len, start_len;

    reset = 1'b1; en = 1'b0; wr = 1'b0; addr = 1'b0; data_in = 8'h00;
    kbd_clk = 1'b1; kbd_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state and interrupt enable
    checkOutput("reset_oe", {14'h0, ps2_clk_oe, ps2_data_oe}, 16'h0);
    readReg(1'b1, rd);
    checkOutput("reset_status", 16'(rd), 16'h01);
    checkOutput("reset_irq_wt", {14'h0, irq, wt}, 16'h0);
    applyStimulus(1'b1, 8'h02);
    checkOutput("ien_irq", 16'(irq), 16'h1);
    readReg(1'b1, rd);
    checkOutput("ien_status", 16'(rd), 16'h03);
    applyStimulus(1'b1, 8'h00);

    // 0xED with ack: inhibit length, start-bit window, line bits, clean completion
    applyStimulus(1'b0, 8'hED);
    readReg(1'b1, rd);
    checkOutput("busy_status", 16'(rd), 16'h00);
    inh_len = 0; start_len = 0;
    while (ps2_clk_oe && inh_len < 100) begin
      inh_len++;
      if (ps2_data_oe) start_len++;
      @(negedge clk);
    end
    checkOutput("inhibit_len", 16'(inh_len), 16'(INH));
    checkOutput("start_len", 16'(start_len), 16'(INH / 2));
    checkOutput("start_bit", 16'(ps2_data_oe), 16'h1);
    kbdClock(10, 1'b1, 1'b1, cap);
    checkOutput("frame_ED", 16'(cap), 16'({1'b1, 1'b1, 8'hED}));
    waitReady("ready_ED", 50);
    readReg(1'b1, rd);
    checkOutput("status_ED", 16'(rd), 16'h01);
    checkOutput("irq_ED", 16'(irq), 16'h0);
    readReg(1'b0, rd);
    checkOutput("datareg_ED", 16'(rd), 16'hED);

    // 0xFF, no ack: err set, irq with ien
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b0, 8'hFF);
    waitRelease("release_FF");
    kbdClock(10, 1'b1, 1'b0, cap);
    checkOutput("frame_FF", 16'(cap), 16'({1'b1, 1'b1, 8'hFF}));
    waitReady("ready_FF", 50);
    readReg(1'b1, rd);
    checkOutput("status_FF", 16'(rd), 16'h07);
    checkOutput("irq_FF", 16'(irq), 16'h1);
    applyStimulus(1'b1, 8'h00);

    // 0x55, keyboard stops after 4 bits: timeout
    applyStimulus(1'b0, 8'h55);
    waitRelease("release_55");
    kbdClock(4, 1'b0, 1'b0, cap);
    checkOutput("bits_55", 16'(cap[3:0]), 16'h5);
    readReg(1'b1, rd);
    checkOutput("no_early_timeout", 16'(rd), 16'h00);
    checkOutput("held_oe_55", 16'(ps2_data_oe), 16'h1);
    waitReady("ready_timeout", TMO + 50);
    @(negedge clk);
    checkOutput("timeout_oe", {14'h0, ps2_clk_oe, ps2_data_oe}, 16'h0);
    readReg(1'b1, rd);
    checkOutput("timeout_status", 16'(rd), 16'h05);

    // 0xF4 with a write of 0xAA while busy
    applyStimulus(1'b0, 8'hF4);
    waitRelease("release_F4");
    fork
      kbdClock(10, 1'b1, 1'b1, cap);
      begin
        repeat (100) @(negedge clk);
        applyStimulus(1'b0, 8'hAA);
      end
    join
    checkOutput("frame_F4", 16'(cap), 16'({1'b1, 1'b0, 8'hF4}));
    waitReady("ready_F4", 50);
    readReg(1'b1, rd);
    checkOutput("status_F4", 16'(rd), 16'h01);
    readReg(1'b0, rd);
    checkOutput("datareg_F4", 16'(rd), 16'hF4);

    // Reset during SEND, then a clean frame
    applyStimulus(1'b0, 8'hF4);
    waitRelease("release_rst");
    checkOutput("send_oe_pre", 16'(ps2_data_oe), 16'h1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_oe", {14'h0, ps2_clk_oe, ps2_data_oe}, 16'h0);
    reset = 1'b0;
    @(negedge clk);
    readReg(1'b1, rd);
    checkOutput("reset_mid_status", 16'(rd), 16'h01);
    applyStimulus(1'b0, 8'hF4);
    waitRelease("release_F4b");
    kbdClock(10, 1'b1, 1'b1, cap);
    checkOutput("frame_F4b", 16'(cap), 16'({1'b1, 1'b0, 8'hF4}));
    waitReady("ready_F4b", 50);
    readReg(1'b1, rd);
    checkOutput("status_F4b", 16'(rd), 16'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
